// File: rtl/wpack_pkg.sv
// Shared constants, types and configuration checks for the AHB write-side
// pixel packing FIFO.
package wpack_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int PIX_W_DEF  = 8;
    localparam int LANES_DEF  = 2;
    localparam int DEPTH_DEF  = 4;

    localparam int SLOTS = DATA_W_DEF / PIX_W_DEF;
    localparam int CNT_W = $clog2(SLOTS + 1);

    typedef logic [CNT_W-1:0]      fill_cnt_t;
    typedef logic [DATA_W_DEF-1:0] word_t;

    // Every bit of the flush padding is set; replicated to PIX_W by users.
    localparam logic PAD_BIT = 1'b1;

    typedef enum logic {
        FL_IDLE,
        FL_PAD_WAIT
    } flush_state_t;

    function automatic int slots_of(input int data_w, input int pix_w);
        return data_w / pix_w;
    endfunction

    function automatic bit cfg_ok(input int data_w, input int pix_w,
                                  input int lanes, input int depth);
        return (pix_w > 0) && (lanes > 0) &&
               (data_w % pix_w == 0) &&
               (data_w % (lanes * pix_w) == 0) &&
               (depth >= 2) && ((depth & (depth - 1)) == 0);
    endfunction

endpackage

// File: rtl/ahb_wpack_fifo_if.sv
// Pixel-side push/flush handshake and AHB-side word handshake of the packing FIFO.
interface ahb_wpack_fifo_if #(
    parameter int DATA_W = 32,
    parameter int PIX_W  = 8,
    parameter int LANES  = 2,
    parameter int DEPTH  = 4
);
    logic                     shift_enable;
    logic [LANES*PIX_W-1:0]   pix_in;
    logic                     in_ready;
    logic                     flush;
    logic [DATA_W-1:0]        HWDATA;
    logic                     word_valid;
    logic                     beat_done;
    logic [$clog2(DEPTH):0]   word_count;
    logic                     flush_done;
    logic                     overflow;

    modport slave (
        input  shift_enable, pix_in, flush, beat_done,
        output in_ready, HWDATA, word_valid, word_count, flush_done, overflow
    );

    modport master (
        output shift_enable, pix_in, flush, beat_done,
        input  in_ready, HWDATA, word_valid, word_count, flush_done, overflow
    );
endinterface

// File: rtl/wpack_word_fifo.sv
// Show-ahead word FIFO: head entry is presented combinationally, all ones when empty.
module wpack_word_fifo #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic                   HCLK,
    input  logic                   HRESETn,
    input  logic                   push,
    input  logic [DATA_W-1:0]      push_data,
    input  logic                   pop,
    output logic [DATA_W-1:0]      rdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [AW:0]       count_q, count_d;
    logic              do_push, do_pop;

    assign empty = (count_q == '0);
    assign full  = (count_q == (AW+1)'(DEPTH));
    assign count = count_q;
    assign rdata = empty ? '1 : mem_q[rd_ptr_q];

    // NOTE: every variable gets a default before any branch so no latch is inferred.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        do_pop   = pop && !empty;
        do_push  = push && (!full || do_pop);

        if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);

        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage is not reset; count_q gates every read, so stale contents never escape.
    always_ff @(posedge HCLK) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/ahb_wpack_fifo.sv
// Packs LANES pixels per push into DATA_W words (earliest pixel most significant)
// and queues them for the AHB master; supports padded flush and sticky overflow.
module ahb_wpack_fifo
    import wpack_pkg::*;
#(
    parameter int               DATA_W = DATA_W_DEF,
    parameter int               PIX_W  = PIX_W_DEF,
    parameter int               LANES  = LANES_DEF,
    parameter int               DEPTH  = DEPTH_DEF,
    parameter logic [PIX_W-1:0] PAD    = {PIX_W{PAD_BIT}}
) (
    input  logic           HCLK,
    input  logic           HRESETn,
    ahb_wpack_fifo_if.slave bus
);
    localparam int N_SLOTS = slots_of(DATA_W, PIX_W);
    localparam int FW      = $clog2(N_SLOTS + 1);
    localparam int CW      = $clog2(DEPTH) + 1;
    localparam logic [DATA_W-1:0] EMPTY_WORD = {N_SLOTS{PAD}};

    if (!cfg_ok(DATA_W, PIX_W, LANES, DEPTH)) begin : g_cfg_bad
        $error("ahb_wpack_fifo: illegal DATA_W/PIX_W/LANES/DEPTH combination");
    end

    logic [DATA_W-1:0] asm_q, asm_d;
    logic [FW-1:0]     fill_q, fill_d;
    flush_state_t      state_q, state_d;
    logic              overflow_q, overflow_d;

    logic [DATA_W-1:0] packed_word;
    logic [DATA_W-1:0] push_data;
    logic              push_word;
    logic              completes, room, accept, in_ready, flush_done;

    logic [DATA_W-1:0] fifo_rdata;
    logic              fifo_full, fifo_empty;
    logic [CW-1:0]     fifo_count;

    always_comb begin
        asm_d       = asm_q;
        fill_d      = fill_q;
        state_d     = state_q;
        overflow_d  = overflow_q;
        push_word   = 1'b0;
        push_data   = asm_q;
        flush_done  = 1'b0;

        room      = !fifo_full || (bus.beat_done && !fifo_empty);
        completes = (fill_q == FW'(N_SLOTS - LANES));
        in_ready  = (state_q == FL_IDLE) && (!completes || room);
        accept    = bus.shift_enable && in_ready;

        if (bus.shift_enable && !in_ready) overflow_d = 1'b1;

        // Lane l lands in slot fill+l; slot 0 is the most-significant pixel.
        packed_word = asm_q;
        for (int l = 0; l < LANES; l++) begin
            packed_word[DATA_W-1-(int'(fill_q)+l)*PIX_W -: PIX_W] = bus.pix_in[l*PIX_W +: PIX_W];
        end

        if (accept) begin
            if (completes) begin
                push_word = 1'b1;
                push_data = packed_word;
                asm_d     = EMPTY_WORD;
                fill_d    = '0;
            end else begin
                asm_d  = packed_word;
                fill_d = fill_q + FW'(LANES);
            end
        end

        // Flush acts on the post-push assembler; at most one FIFO write per cycle
        // because a completing push leaves fill_d at zero.
        unique case (state_q)
            FL_IDLE: begin
                if (bus.flush) begin
                    if (fill_d == '0) begin
                        flush_done = 1'b1;
                    end else if (room) begin
                        push_word  = 1'b1;
                        push_data  = asm_d;
                        asm_d      = EMPTY_WORD;
                        fill_d     = '0;
                        flush_done = 1'b1;
                    end else begin
                        state_d = FL_PAD_WAIT;
                    end
                end
            end
            FL_PAD_WAIT: begin
                if (room) begin
                    push_word  = 1'b1;
                    push_data  = asm_q;
                    asm_d      = EMPTY_WORD;
                    fill_d     = '0;
                    flush_done = 1'b1;
                    state_d    = FL_IDLE;
                end
            end
            default: state_d = FL_IDLE;
        endcase
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            asm_q      <= EMPTY_WORD;
            fill_q     <= '0;
            state_q    <= FL_IDLE;
            overflow_q <= 1'b0;
        end else begin
            asm_q      <= asm_d;
            fill_q     <= fill_d;
            state_q    <= state_d;
            overflow_q <= overflow_d;
        end
    end

    wpack_word_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .HCLK      (HCLK),
        .HRESETn   (HRESETn),
        .push      (push_word),
        .push_data (push_data),
        .pop       (bus.beat_done),
        .rdata     (fifo_rdata),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign bus.HWDATA     = fifo_rdata;
    assign bus.word_valid = !fifo_empty;
    assign bus.word_count = fifo_count;
    assign bus.in_ready   = in_ready;
    assign bus.flush_done = flush_done;
    assign bus.overflow   = overflow_q;

endmodule

// File: tb/tb_ahb_wpack_fifo.sv
// Directed bench for ahb_wpack_fifo: stimulus queues expected words, a
// negedge monitor pops and compares each word the AHB side accepts.
module tb_ahb_wpack_fifo;
    import wpack_pkg::*;

    logic HCLK    = 1'b0;
    logic HRESETn = 1'b0;
    always #5 HCLK = ~HCLK;

    ahb_wpack_fifo_if #(.DATA_W(32), .PIX_W(8), .LANES(2), .DEPTH(4)) bus ();

    ahb_wpack_fifo #(
        .DATA_W (32),
        .PIX_W  (8),
        .LANES  (2),
        .DEPTH  (4),
        .PAD    (8'hFF)
    ) dut (
        .HCLK    (HCLK),
        .HRESETn (HRESETn),
        .bus     (bus)
    );

    int          n_tests      = 0;
    int          n_fail       = 0;
    int          flush_pulses = 0;
    logic [31:0] exp_q [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: a beat is consumed whenever beat_done meets word_valid.
    always @(negedge HCLK) begin
        if (HRESETn && bus.flush_done) flush_pulses++;
        if (HRESETn && bus.beat_done && bus.word_valid) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL sb_underrun: got %h expected no word at %0t", bus.HWDATA, $time);
            end else begin
                check("sb_word", bus.HWDATA, exp_q.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    task automatic drive(input bit se, input logic [15:0] pix, input bit fl, input bit bd);
        bus.shift_enable = se;
        bus.pix_in       = pix;
        bus.flush        = fl;
        bus.beat_done    = bd;
    endtask

    task automatic idle();
        drive(1'b0, 16'h0000, 1'b0, 1'b0);
    endtask

    // Word i is built from bytes {i0, i1, i2, i3}, pushed as {i1,i0} then {i3,i2}.
    function automatic logic [15:0] half(input int i, input int h);
        logic [7:0] b = 8'(i * 16 + 2 * h);
        return {b + 8'd1, b};
    endfunction

    function automatic logic [31:0] mkw(input int i);
        logic [7:0] b = 8'(i * 16);
        return {b, b + 8'd1, b + 8'd2, b + 8'd3};
    endfunction

    task automatic push_word(input int i);
        drive(1'b1, half(i, 0), 1'b0, 1'b0);
        tick();
        drive(1'b1, half(i, 1), 1'b0, 1'b0);
        exp_q.push_back(mkw(i));
        tick();
        idle();
    endtask

    task automatic drain(input int n);
        bus.beat_done = 1'b1;
        repeat (n) tick();
        bus.beat_done = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_hwdata"},     bus.HWDATA, 32'hFFFF_FFFF);
        check({tag, "_word_valid"}, 32'(bus.word_valid), 32'd0);
        check({tag, "_word_count"}, 32'(bus.word_count), 32'd0);
        check({tag, "_in_ready"},   32'(bus.in_ready), 32'd1);
        check({tag, "_flush_done"}, 32'(bus.flush_done), 32'd0);
        check({tag, "_overflow"},   32'(bus.overflow), 32'd0);
    endtask

    initial begin
        int p0;
        idle();
        #12;
        check_reset_outputs("rst");
        @(negedge HCLK);
        HRESETn = 1'b1;
        tick();

        // Two pushes make one word, visible right after the completing edge.
        drive(1'b1, 16'h2211, 1'b0, 1'b0);
        tick();
        drive(1'b1, 16'h4433, 1'b0, 1'b0);
        exp_q.push_back(32'h1122_3344);
        tick();
        idle();
        check("first_valid",  32'(bus.word_valid), 32'd1);
        check("first_hwdata", bus.HWDATA, 32'h1122_3344);
        check("first_count",  32'(bus.word_count), 32'd1);
        drain(1);
        check("pop_empty_valid",  32'(bus.word_valid), 32'd0);
        check("pop_empty_hwdata", bus.HWDATA, 32'hFFFF_FFFF);

        // Beat on an empty FIFO is ignored.
        drain(1);
        check("empty_beat_count", 32'(bus.word_count), 32'd0);

        // Fill to DEPTH, then a completing push with a simultaneous pop.
        for (int i = 1; i <= 4; i++) push_word(i);
        check("full_count", 32'(bus.word_count), 32'd4);
        check("full_head",  bus.HWDATA, mkw(1));
        drive(1'b1, half(5, 0), 1'b0, 1'b0);
        tick();
        drive(1'b1, half(5, 1), 1'b0, 1'b1);
        #1;
        check("full_pop_push_ready", 32'(bus.in_ready), 32'd1);
        exp_q.push_back(mkw(5));
        tick();
        idle();
        check("full_pop_push_count", 32'(bus.word_count), 32'd4);
        check("full_pop_push_ovf",   32'(bus.overflow), 32'd0);

        // Completing push into a full FIFO without a pop is rejected.
        drive(1'b1, half(6, 0), 1'b0, 1'b0);
        #1;
        check("partial_ready_full", 32'(bus.in_ready), 32'd1);
        tick();
        drive(1'b1, half(6, 1), 1'b0, 1'b0);
        #1;
        check("reject_ready", 32'(bus.in_ready), 32'd0);
        tick();
        idle();
        check("reject_overflow", 32'(bus.overflow), 32'd1);
        check("reject_count",    32'(bus.word_count), 32'd4);
        drain(4);
        check("drained_count", 32'(bus.word_count), 32'd0);
        // Assembler kept word 6's first half through the rejection.
        drive(1'b1, half(6, 1), 1'b0, 1'b0);
        exp_q.push_back(mkw(6));
        tick();
        idle();
        check("retry_hwdata", bus.HWDATA, 32'h6061_6263);
        drain(1);

        // Flush of a half word pads with all ones; empty-assembler flush adds nothing.
        p0 = flush_pulses;
        drive(1'b1, 16'hBBAA, 1'b0, 1'b0);
        tick();
        drive(1'b0, 16'h0000, 1'b1, 1'b0);
        #1;
        check("flush_done_now", 32'(bus.flush_done), 32'd1);
        exp_q.push_back(32'hAABB_FFFF);
        tick();
        idle();
        #1;
        check("flush_done_drop", 32'(bus.flush_done), 32'd0);
        check("flush_count",     32'(bus.word_count), 32'd1);
        check("flush_hwdata",    bus.HWDATA, 32'hAABB_FFFF);
        check("flush_pulses_1",  32'(flush_pulses - p0), 32'd1);
        drive(1'b0, 16'h0000, 1'b1, 1'b0);
        #1;
        check("flush_empty_done", 32'(bus.flush_done), 32'd1);
        tick();
        idle();
        check("flush_empty_count", 32'(bus.word_count), 32'd1);
        check("flush_pulses_2",    32'(flush_pulses - p0), 32'd2);
        drain(1);

        // Flush with the FIFO full waits for room, blocking pushes meanwhile.
        for (int i = 7; i <= 10; i++) push_word(i);
        drive(1'b1, half(11, 0), 1'b0, 1'b0);
        tick();
        drive(1'b0, 16'h0000, 1'b1, 1'b0);
        #1;
        check("padwait_no_done", 32'(bus.flush_done), 32'd0);
        tick();
        check("padwait_ready",    32'(bus.in_ready), 32'd0);
        check("padwait_no_done2", 32'(bus.flush_done), 32'd0);
        bus.beat_done = 1'b1;
        #1;
        check("padwait_done", 32'(bus.flush_done), 32'd1);
        exp_q.push_back(32'hB0B1_FFFF);
        tick();
        idle();
        check("padwait_count", 32'(bus.word_count), 32'd4);
        check("padwait_ready_after", 32'(bus.in_ready), 32'd1);
        drain(4);

        // Push and flush in the same cycle: push first, then pad the result.
        drive(1'b1, 16'hDDCC, 1'b1, 1'b0);
        #1;
        check("push_flush_done", 32'(bus.flush_done), 32'd1);
        exp_q.push_back(32'hCCDD_FFFF);
        tick();
        idle();
        check("push_flush_hwdata", bus.HWDATA, 32'hCCDD_FFFF);
        drain(1);

        // Asynchronous reset mid-assembly with three words queued.
        for (int i = 12; i <= 14; i++) push_word(i);
        drive(1'b1, half(15, 0), 1'b0, 1'b0);
        tick();
        idle();
        check("pre_reset_count", 32'(bus.word_count), 32'd3);
        #2;
        HRESETn = 1'b0;
        #1;
        check_reset_outputs("async_rst");
        exp_q.delete();
        @(negedge HCLK);
        HRESETn = 1'b1;
        tick();
        drive(1'b1, 16'h2211, 1'b0, 1'b0);
        tick();
        drive(1'b1, 16'h4433, 1'b0, 1'b0);
        exp_q.push_back(32'h1122_3344);
        tick();
        idle();
        check("post_reset_hwdata", bus.HWDATA, 32'h1122_3344);
        drain(1);

        tick();
        check("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: simulation did not finish by %0t", $time);
        $fatal(1, "timeout");
    end

endmodule
